// File: rtl/mdu_sequencer.sv
// MIPS E-stage multiply/divide sequencer: owns HI/LO, models fixed mult/div
// latency with a busy counter, and raises the D-stage MDU stall request.
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_type,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        cancel,
  input  logic        d_is_mdu,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data,
  output logic        stall_mdu
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [63:0]        pending;
  logic               pending_wr;

  logic               go;
  logic               is_md_op;
  logic signed [63:0] smul;
  logic [63:0]        umul;
  logic [31:0]        abs_a;
  logic [31:0]        abs_b;
  logic [31:0]        mag_q;
  logic [31:0]        mag_r;
  logic [31:0]        sq;
  logic [31:0]        sr;
  logic [31:0]        uq;
  logic [31:0]        ur;

  assign go        = start & ~cancel & (state == IDLE);
  assign is_md_op  = (mdu_type >= 4'd1) && (mdu_type <= 4'd4);
  assign stall_mdu = d_is_mdu & (busy | (start & ~cancel & is_md_op));

  // Result datapath; signed divide works on magnitudes so MIN/-1 wraps to MIN.
  always_comb begin
    smul  = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    umul  = {32'd0, rs_val} * {32'd0, rt_val};
    abs_a = rs_val[31] ? (32'd0 - rs_val) : rs_val;
    abs_b = rt_val[31] ? (32'd0 - rt_val) : rt_val;
    mag_q = 32'd0;
    mag_r = 32'd0;
    uq    = 32'd0;
    ur    = 32'd0;
    if (rt_val != 32'd0) begin
      mag_q = abs_a / abs_b;
      mag_r = abs_a % abs_b;
      uq    = rs_val / rt_val;
      ur    = rs_val % rt_val;
    end else begin
      mag_q = 32'd0;
      mag_r = 32'd0;
      uq    = 32'd0;
      ur    = 32'd0;
    end
    sq = (rs_val[31] ^ rt_val[31]) ? (32'd0 - mag_q) : mag_q;
    sr = rs_val[31] ? (32'd0 - mag_r) : mag_r;
  end

  always_comb begin
    case (mdu_type)
      4'd5:    rd_data = hi;
      4'd6:    rd_data = lo;
      default: rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      count      <= '0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      pending    <= 64'd0;
      pending_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            case (mdu_type)
              4'd1, 4'd2: begin
                pending    <= (mdu_type == 4'd1) ? smul : umul;
                pending_wr <= 1'b1;
                count      <= CNT_W'(MULT_CYCLES);
                state      <= BUSY;
                busy       <= 1'b1;
              end
              4'd3, 4'd4: begin
                pending    <= (mdu_type == 4'd3) ? {sr, sq} : {ur, uq};
                // A zero divisor still occupies the unit but leaves HI/LO alone.
                pending_wr <= (rt_val != 32'd0);
                count      <= CNT_W'(DIV_CYCLES);
                state      <= BUSY;
                busy       <= 1'b1;
              end
              4'd7:    hi <= rs_val;
              4'd8:    lo <= rs_val;
              default: ;
            endcase
          end
        end
        BUSY: begin
          if (count == CNT_W'(1)) begin
            count <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            if (pending_wr) begin
              hi <= pending[63:32];
              lo <= pending[31:0];
            end
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multiply/divide unit sequencer for the E stage of the 5-stage MIPS pipeline.
- Accepts the MDU start strobe and the 4-bit MDU operation type from the decode controller, and owns the HI/LO registers.
- Models the fixed multi-cycle latency of mult/div with a busy counter.
- Produces the D-stage stall request for any MDU-class instruction that arrives while the unit is occupied.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >=1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be >=1)

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  E-stage MduStart strobe (md or mt op valid in E)
- mdu_type  input  4  E-stage op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO
- rs_val  input  32  forwarded rs operand in E
- rt_val  input  32  forwarded rt operand in E
- cancel  input  1  flush of E stage (exception/eret in M); suppresses this cycle's start
- d_is_mdu  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- busy  output  1  multi-cycle operation in progress
- hi  output  32  architectural HI
- lo  output  32  architectural LO
- rd_data  output  32  mfhi→hi, mflo→lo, else 0 (combinational from mdu_type)
- stall_mdu  output  1  D-stage stall request

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE, busy=0, counter=0, hi=0, lo=0, pending result discarded.
- Operation is accepted when go = start & ~cancel & state==IDLE. In BUSY, start is ignored (unreachable given stall_mdu; no side effects).
- States: IDLE, BUSY.
- IDLE, go with type 1–4:
  - latch the 64-bit result into a pending register
  - load counter with MULT_CYCLES or DIV_CYCLES
  - go to BUSY
  - busy=1 from the next cycle
- BUSY, each edge: counter decrements. At the edge where counter==1:
  - hi/lo take the pending result
  - counter=0, state=IDLE
  - busy falls in the same edge.
- Timing: start accepted in cycle T → busy high T+1..T+N → hi/lo new value visible from T+N+1 (N = 5 or 10).
- mthi/mtlo (7/8) with go: hi or lo = rs_val at the next edge. No busy. The other register is unchanged.
- mfhi/mflo: pure combinational read. The value is the current hi/lo register, not the pending result.
- Types 0, 5, 6 with start: no state change.
- Arithmetic:
  - mult: {hi,lo} = signed(rs)*signed(rt), 64-bit
  - multu: unsigned product
  - div: lo = quotient truncated toward zero; hi = remainder with the dividend's sign
  - divu: unsigned quotient/remainder
- Divide by zero (rt_val==0): busy sequence runs normally, hi/lo unchanged at completion.
- Signed div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- cancel:
  - blocks go in the same cycle only.
  - Does not abort an operation already in BUSY; that op belongs to an older committed instruction.
  - cancel with mthi/mtlo also blocks the write.
- stall_mdu = d_is_mdu & (busy | (start & ~cancel & mdu_type in 1..4)). Combinational; a D-stage MDU instruction waits through the whole busy window.
- Operands are captured only at acceptance; later changes on rs_val/rt_val have no effect.

Test Plan:
- Reset, then start=1, type=1 (mult), rs=0xFFFFFFFE (-2), rt=3:
  - busy=1 exactly 5 cycles
  - hi=0xFFFFFFFF, lo=0xFFFFFFFA on cycle 6
  - hi/lo still 0 during busy
- type=4 (divu), rs=100, rt=7 → busy 10 cycles; then lo=14, hi=2. type=3 (div), rs=-7, rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Boundary values:
  - div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0
  - divu by 0 with hi=0x11, lo=0x22 preset via mthi/mtlo → busy 10 cycles, hi/lo remain 0x11/0x22
- Stall and ignored start:
  - mult started, d_is_mdu=1 held → stall_mdu=1 in the start cycle and all 5 busy cycles, 0 afterwards
  - a start during busy does not alter counter or result
- start=1 type=1 with cancel=1 → busy stays 0, hi/lo unchanged. mtlo with cancel=1 → lo unchanged.
- Reset asserted mid-div (cycle 4 of 10) → busy, hi, lo = 0 immediately (async). After release, idle with no late write-back.
